// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    size_e       size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake between the core and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/load_align.sv
// Moves the addressed byte/half of a RAM word down to bit 0 and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        uns_i,
  output logic [31:0] data_c_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = word_i >> {lane_i, 3'b000};
    data_c_o = '0;
    case (size_i)
      SIZE_B:  data_c_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  data_c_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
      SIZE_W:  data_c_o = shifted;
      default: data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, applies WAIT_CYCLES wait
// states, then returns extended load data or an error flag.
module dmem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  // Below-base addresses wrap to large offsets, so one compare covers both ends.
  function automatic logic req_bad(logic [31:0] a, size_e s);
    logic misalign;
    misalign = ((s == SIZE_H) && a[0]) || ((s == SIZE_W) && (a[1:0] != 2'b00));
    return (s == SIZE_ILL) || misalign || ((a - BASE_ADDR) >= SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic             fire;
  logic             resp_hs;
  logic             mem_we;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic [31:0]      ld_word;
  logic [31:0]      ld_data;
  logic [31:0]      mem_q [DEPTH_WORDS];

  assign fire    = bus.req_valid && req_ready_q;
  assign resp_hs = resp_valid_q && bus.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          req_d.we    = bus.req_we;
          req_d.addr  = bus.req_addr;
          req_d.size  = size_e'(bus.req_size);
          req_d.uns   = bus.req_unsigned;
          req_d.wdata = bus.req_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers lag RESP entry by one cycle: that cycle is the RAM read.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    if ((state_q == RESP) && !resp_hs) begin
      resp_valid_d = 1'b1;
      if (resp_valid_q) begin
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
      end else begin
        resp_err_d   = req_bad(req_q.addr, req_q.size);
        resp_rdata_d = (resp_err_d || req_q.we) ? '0 : ld_data;
      end
    end
  end

  // Store lane merge, taken from the request as it enters RESP.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = '0;
    case (req_d.size)
      SIZE_B: begin
        wr_be   = 4'b0001 << req_d.addr[1:0];
        wr_data = {4{req_d.wdata[7:0]}};
      end
      SIZE_H: begin
        wr_be   = req_d.addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_d.wdata[15:0]}};
      end
      SIZE_W: begin
        wr_be   = 4'b1111;
        wr_data = req_d.wdata;
      end
      default: ;
    endcase
  end

  assign mem_we = (state_d == RESP) && (state_q != RESP) && req_d.we
                  && !req_bad(req_d.addr, req_d.size);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[word_idx(req_d.addr)][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign ld_word = mem_q[word_idx(req_q.addr)];

  load_align u_load_align (
    .word_i   (ld_word),
    .lane_i   (req_q.addr[1:0]),
    .size_i   (req_q.size),
    .uns_i    (req_q.uns),
    .data_c_o (ld_data)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder (WAIT_CYCLES 0 and 3) against a byte-array model.
module tb_dmem_responder;

  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam int unsigned NBYTES = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_we, req_unsigned, resp_ready;
  logic [1:0]  req_ready, resp_valid, resp_err;
  logic [31:0] req_addr   [2];
  logic [1:0]  req_size   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    dmem_responder_if bus ();
    assign bus.req_valid    = req_valid[g];
    assign bus.req_we       = req_we[g];
    assign bus.req_addr     = req_addr[g];
    assign bus.req_size     = req_size[g];
    assign bus.req_unsigned = req_unsigned[g];
    assign bus.req_wdata    = req_wdata[g];
    assign bus.resp_ready   = resp_ready[g];
    assign req_ready[g]     = bus.req_ready;
    assign resp_valid[g]    = bus.resp_valid;
    assign resp_err[g]      = bus.resp_err;
    assign resp_rdata[g]    = bus.resp_rdata;

    dmem_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (256),
      .WAIT_CYCLES ((g == 0) ? 0 : 3)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int n_checks;
  int n_fail;

  // Little-endian byte image of each instance's RAM window.
  logic [7:0] mdl [2][NBYTES];

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    int nb;
    int off;
    longint unsigned a;
    logic [31:0] v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a   = 64'(addr);
    rd  = '0;
    err = (size == 2'd3) || ((int'(addr[1:0]) % nb) != 0) || (a < 64'(BASE))
          || (a >= 64'(BASE) + 64'(NBYTES));
    if (err) return;
    off = int'(a - 64'(BASE));
    if (we) begin
      for (int i = 0; i < nb; i++) mdl[d][off + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[d][off + i];
      if (!uns && (nb < 4) && v[8*nb - 1]) begin
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rd = v;
    end
  endfunction

  task automatic drive_req(input int d, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_addr[d]     = addr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_wdata[d]    = wdata;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check($sformatf("d%0d accept_timeout", d), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid[d]) check($sformatf("d%0d resp_timeout", d), 32'd0, 32'd1);
  endtask

  task automatic finish_resp(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check($sformatf("d%0d resp_valid_drop", d), 32'(resp_valid[d]), 32'd0);
    check($sformatf("d%0d req_ready_back", d), 32'(req_ready[d]), 32'd1);
  endtask

  task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    model(d, we, addr, size, uns, wdata, exp_rd, exp_err);
    drive_req(d, we, addr, size, uns, wdata);
    wait_resp(d, lat);
    check($sformatf("d%0d latency @%08h", d, addr), 32'(lat), 32'(waits_of(d) + 1));
    check($sformatf("d%0d rdata we=%0b sz=%0d @%08h", d, we, size, addr), resp_rdata[d], exp_rd);
    check($sformatf("d%0d err we=%0b sz=%0d @%08h", d, we, size, addr), 32'(resp_err[d]), 32'(exp_err));
    rd = resp_rdata[d];
    finish_resp(d);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] addr;
    logic [1:0]  sz;
    int          sel;
    int          lat;
    logic        stray;

    n_checks = 0;
    n_fail   = 0;
    req_valid = '0; req_we = '0; req_unsigned = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = BASE; req_size[d] = 2'd2; req_wdata[d] = '0;
    end

    // Reset held with a request pending on both instances.
    rst       = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d rst req_ready", d), 32'(req_ready[d]), 32'd0);
        check($sformatf("d%0d rst resp_valid", d), 32'(resp_valid[d]), 32'd0);
        check($sformatf("d%0d rst resp_rdata", d), resp_rdata[d], 32'd0);
        check($sformatf("d%0d rst resp_err", d), 32'(resp_err[d]), 32'd0);
      end
    end
    rst       = 1'b0;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d post-rst req_ready", d), 32'(req_ready[d]), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d no accept in rst", d), 32'(resp_valid[d]), 32'd0);

    for (int d = 0; d < 2; d++) begin
      // Give the exercised words defined contents.
      for (int w = 0; w < 16; w++) xact(d, 1'b1, BASE + 32'(4 * w), 2'd2, 1'b0, $urandom, rd);
      xact(d, 1'b1, BASE + 32'h3FC, 2'd2, 1'b0, $urandom, rd);

      xact(d, 1'b1, BASE, 2'd2, 1'b0, 32'hDEAD_BEEF, rd);
      xact(d, 1'b0, BASE, 2'd2, 1'b0, 32'h0, rd);
      check($sformatf("d%0d lw roundtrip", d), rd, 32'hDEAD_BEEF);

      xact(d, 1'b1, BASE + 32'd3, 2'd0, 1'b0, 32'h0000_0080, rd);
      xact(d, 1'b0, BASE + 32'd3, 2'd0, 1'b0, 32'h0, rd);
      check($sformatf("d%0d lb", d), rd, 32'hFFFF_FF80);
      xact(d, 1'b0, BASE + 32'd3, 2'd0, 1'b1, 32'h0, rd);
      check($sformatf("d%0d lbu", d), rd, 32'h0000_0080);
      xact(d, 1'b0, BASE, 2'd2, 1'b0, 32'h0, rd);
      check($sformatf("d%0d lw after sb", d), rd, 32'h80AD_BEEF);
      xact(d, 1'b0, BASE + 32'd2, 2'd1, 1'b0, 32'h0, rd);
      check($sformatf("d%0d lh", d), rd, 32'hFFFF_80AD);

      // Rejected requests must leave word 0 alone.
      xact(d, 1'b1, BASE + 32'd1, 2'd1, 1'b0, 32'h0000_FFFF, rd);
      xact(d, 1'b0, BASE + 32'h400, 2'd2, 1'b0, 32'h0, rd);
      xact(d, 1'b1, BASE - 32'd4, 2'd2, 1'b0, 32'h1111_1111, rd);
      xact(d, 1'b1, BASE, 2'd3, 1'b0, 32'h2222_2222, rd);
      xact(d, 1'b0, BASE, 2'd2, 1'b0, 32'h0, rd);
      check($sformatf("d%0d word after errors", d), rd, 32'h80AD_BEEF);

      // Response held under backpressure.
      model(d, 1'b0, BASE + 32'd2, 2'd1, 1'b1, 32'h0, exp_rd, exp_err);
      drive_req(d, 1'b0, BASE + 32'd2, 2'd1, 1'b1, 32'h0);
      wait_resp(d, lat);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        check($sformatf("d%0d bp resp_valid c%0d", d, c), 32'(resp_valid[d]), 32'd1);
        check($sformatf("d%0d bp rdata c%0d", d, c), resp_rdata[d], exp_rd);
        check($sformatf("d%0d bp err c%0d", d, c), 32'(resp_err[d]), 32'(exp_err));
        check($sformatf("d%0d bp req_ready c%0d", d, c), 32'(req_ready[d]), 32'd0);
      end
      check($sformatf("d%0d bp value", d), resp_rdata[d], 32'h0000_80AD);
      finish_resp(d);
    end

    // Reset during WAIT drops a pending store (model left untouched).
    drive_req(1, 1'b1, BASE + 32'd4, 2'd2, 1'b0, 32'h1234_5678);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("d1 rst-in-wait req_ready", 32'(req_ready[1]), 32'd0);
    check("d1 rst-in-wait resp_valid", 32'(resp_valid[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("d1 ready after wait-rst", 32'(req_ready[1]), 32'd1);
    stray = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      stray = stray | resp_valid[1];
    end
    check("d1 no resp after wait-rst", 32'(stray), 32'd0);
    xact(1, 1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'h0, rd);

    // Random mix of in-range, edge and out-of-window accesses.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7)      addr = BASE + $urandom_range(0, 63);
        else if (sel < 8) addr = BASE + 32'h3FC + $urandom_range(0, 3);
        else if (sel < 9) addr = BASE - 32'd4 + $urandom_range(0, 3);
        else              addr = BASE + 32'h400 + $urandom_range(0, 7);
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        xact(d, 1'($urandom_range(0, 1)), addr, sz, 1'($urandom_range(0, 1)), $urandom, rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake, performs byte/half/word access into a word-organised RAM mapped at the data segment, and returns a response with read data or an error flag. It sits between the core's load/store path and the on-chip data RAM. It replaces the zero-latency memory model so that cores with stall logic can be exercised against configurable wait states.

## Interface

Parameters:
- BASE_ADDR, 32'h10010000, byte address of word 0; the stack top 0x100103FC lies inside the default window.
- DEPTH_WORDS, 256, RAM depth in 32-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 1, extra cycles between accept and response; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  request was rejected (no memory effect).

## Operation

- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: count down WAIT_CYCLES.
  - RESP: resp_valid = 1.
- Accept when req_valid && req_ready in IDLE. On acceptance, capture we, addr, size, unsigned and wdata.
  - Go to WAIT if WAIT_CYCLES > 0; otherwise go to RESP.
- Error conditions, evaluated on the captured request:
  - size == 11.
  - Misaligned access: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - Address outside [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS).
  - On error: resp_err = 1, resp_rdata = 0, and memory is not written.
- Word index = (addr − BASE_ADDR) >> 2. Byte lane = addr[1:0].
- Stores write only the addressed lanes:
  - byte: lane addr[1:0].
  - half: lanes addr[1]·2 and addr[1]·2+1.
  - word: all four lanes.
  - Other bytes are unchanged.
- The RAM write commits on the edge that enters RESP, and nowhere else.
- Loads read the word, shift the addressed lane(s) to bit 0, then sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready, then the FSM returns to IDLE.
- req_ready is 0 in WAIT and RESP; there is no request pipelining.

## Timing

- Reset values (while rst is high and on the first cycle after it falls):
  - state = IDLE, req_ready = 0 while rst is asserted, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - req_ready = 1 from the first cycle after rst deasserts.
- Latency: if a request is accepted at edge N, resp_valid is high from edge N+1+WAIT_CYCLES.
- A response handshake at edge M gives req_ready = 1 after edge M. The next accept is therefore at M+1 at the earliest.
- A store is visible to any load accepted after that store's response.
- Reset mid-operation:
  - Asserting rst in WAIT drops the request. A pending store is not written.
  - Asserting rst in RESP discards the response; a store has already committed.
- RAM contents are not cleared by rst and are undefined at power-up.
- Wait counter width: $clog2(WAIT_CYCLES+1), minimum 1 bit.

## Structure

- Package mem_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W.
  - the state enum {IDLE, WAIT, RESP}.
  - DMEM_BASE = 32'h10010000.
- Sub-module load_align: purely combinational. It takes (word, lane, size, unsigned) and produces the extended 32-bit value.
- Store lane merge and the FSM are done inline.

## Test plan

- Reset: hold rst high for 3 cycles with req_valid = 1.
  - During reset: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - After release: req_ready = 1 next cycle, and no request was accepted during reset.
- Word round-trip: sw 0xDEADBEEF @0x10010000, then lw @0x10010000.
  - resp_rdata = 0xDEADBEEF, resp_err = 0.
  - resp_valid rises exactly WAIT_CYCLES+1 cycles after each accept; check with WAIT_CYCLES = 0 and 3.
- Sub-word lanes: after the word write, sb 0x80 @0x10010003.
  - lb → 0xFFFFFF80; lbu → 0x00000080; lw → 0x80ADBEEF.
  - Then lh @0x10010002 → 0xFFFF80AD.
- Errors: each must return resp_err = 1, resp_rdata = 0, and leave the word unchanged.
  - sh @0x10010001.
  - lw @0x10010400.
  - sw @0x1000FFFC.
  - size = 11 @0x10010000.
- Backpressure: hold resp_ready = 0 for 5 cycles during a load.
  - resp_valid, resp_rdata and resp_err stay stable, and req_ready stays 0.
  - After resp_ready = 1: one handshake, then req_ready = 1.
- Reset in WAIT: with WAIT_CYCLES = 3, issue sw 0x12345678 @0x10010004 and pulse rst during WAIT.
  - A later lw @0x10010004 returns the prior contents.
